// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the bimodal branch predictor.
// The fetch/execute side uses the master modport and the predictor uses the slave modport.
interface branch_predictor_if #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 32
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  logic              lookupValid;
  logic [31:0]       lookupPc;
  logic              lookupReady;
  logic              predValid;
  logic              predTaken;
  logic [IDX_W-1:0]  predIdx;
  logic              updValid;
  logic [IDX_W-1:0]  updIdx;
  logic              updTaken;
  logic              updPredTaken;
  logic              flush;
  logic              flushBusy;
  logic [CNT_W-1:0]  mispredCount;

  modport master (
    output lookupValid, lookupPc, updValid, updIdx, updTaken, updPredTaken, flush,
    input  lookupReady, predValid, predTaken, predIdx, flushBusy, mispredCount
  );

  modport slave (
    input  lookupValid, lookupPc, updValid, updIdx, updTaken, updPredTaken, flush,
    output lookupReady, predValid, predTaken, predIdx, flushBusy, mispredCount
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch predictor with misprediction counter and sweep flush.
// Optional GSHARE_EN macro XORs a global history register into the lookup index.
module branch_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bus
);
  localparam int unsigned    IDX_W    = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
  localparam logic [1:0]     CNT_INIT = 2'b01;
  localparam logic [0:0]     ST_IDLE  = 1'b0;
  localparam logic [0:0]     ST_SWEEP = 1'b1;

  logic [0:0]       state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [1:0]       cnt_tbl [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic             accept;
  logic             upd_en;
  logic [1:0]       upd_old;
  logic [1:0]       upd_new;
  logic             pred_taken_c;

  logic             pred_valid_q;
  logic             pred_taken_q;
  logic [IDX_W-1:0] pred_idx_q;
  logic             busy_q;
  logic             ready_q;
  logic [CNT_W-1:0] mis_q;

  logic             unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookupPc[31:IDX_W+2], bus.lookupPc[1:0]};

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr;

  assign lk_idx = bus.lookupPc[IDX_W+1:2] ^ ghr;

  // History shifts on every trained branch; cleared when a sweep completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr <= '0;
    end else if (state == ST_SWEEP && ptr == LAST_IDX) begin
      ghr <= '0;
    end else if (upd_en) begin
      ghr <= {ghr[IDX_W-2:0], bus.updTaken};
    end
  end
`else
  assign lk_idx = bus.lookupPc[IDX_W+1:2];
`endif

  assign accept = bus.lookupValid && ready_q;
  assign upd_en = bus.updValid && (state == ST_IDLE);
  assign upd_old = cnt_tbl[bus.updIdx];

  // Saturating counter step
  always_comb begin
    upd_new = upd_old;
    if (bus.updTaken) begin
      if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
    end
  end

  // Same-cycle update to the looked-up entry is forwarded into the prediction
  always_comb begin
    pred_taken_c = cnt_tbl[lk_idx][1];
    if (upd_en && (bus.updIdx == lk_idx)) pred_taken_c = upd_new[1];
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    case (state)
      ST_IDLE: begin
        if (bus.flush) begin
          state_nx = ST_SWEEP;
          ptr_nx   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_nx = ptr + IDX_W'(1);
        if (ptr == LAST_IDX) begin
          state_nx = ST_IDLE;
          ptr_nx   = '0;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      busy_q  <= (state_nx == ST_SWEEP);
      ready_q <= (state_nx == ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_tbl[i] <= CNT_INIT;
    end else if (state == ST_SWEEP) begin
      cnt_tbl[ptr] <= CNT_INIT;
    end else if (upd_en) begin
      cnt_tbl[bus.updIdx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= accept;
      if (accept) begin
        pred_taken_q <= pred_taken_c;
        pred_idx_q   <= lk_idx;
      end
    end
  end

  // Misprediction count saturates rather than wrapping; flush leaves it alone
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= '0;
    end else if (upd_en && (bus.updTaken != bus.updPredTaken) && (mis_q != '1)) begin
      mis_q <= mis_q + CNT_W'(1);
    end
  end

  assign bus.lookupReady  = ready_q;
  assign bus.predValid    = pred_valid_q;
  assign bus.predTaken    = pred_taken_q;
  assign bus.predIdx      = pred_idx_q;
  assign bus.flushBusy    = busy_q;
  assign bus.mispredCount = mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (bimodal build, ENTRIES=64).
// A second instance with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_branch_predictor;
  localparam int unsigned ENTRIES = 64;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  branch_predictor_if #(.ENTRIES(ENTRIES), .CNT_W(32)) bus  ();
  branch_predictor_if #(.ENTRIES(ENTRIES), .CNT_W(4))  bus4 ();

  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(32)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(4))  u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  assign bus4.lookupValid  = bus.lookupValid;
  assign bus4.lookupPc     = bus.lookupPc;
  assign bus4.updValid     = bus.updValid;
  assign bus4.updIdx       = bus.updIdx;
  assign bus4.updTaken     = bus.updTaken;
  assign bus4.updPredTaken = bus.updPredTaken;
  assign bus4.flush        = bus.flush;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc);
    bus.lookupValid = 1'b1;
    bus.lookupPc    = pc;
    step();
    bus.lookupValid = 1'b0;
  endtask

  task automatic upd(input logic [IDX_W-1:0] idx, input logic taken, input logic pred);
    bus.updValid     = 1'b1;
    bus.updIdx       = idx;
    bus.updTaken     = taken;
    bus.updPredTaken = pred;
    step();
    bus.updValid = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int errs;
    n_tests = 0;
    n_fail  = 0;
    rst_n            = 1'b0;
    bus.lookupValid  = 1'b0;
    bus.lookupPc     = '0;
    bus.updValid     = 1'b0;
    bus.updIdx       = '0;
    bus.updTaken     = 1'b0;
    bus.updPredTaken = 1'b0;
    bus.flush        = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pred_valid", 32'(bus.predValid), 32'd0);
    check("rst_pred_taken", 32'(bus.predTaken), 32'd0);
    check("rst_pred_idx", 32'(bus.predIdx), 32'd0);
    check("rst_mispred", bus.mispredCount, 32'd0);
    check("rst_flush_busy", 32'(bus.flushBusy), 32'd0);
    check("rst_lookup_ready", 32'(bus.lookupReady), 32'd1);
    rst_n = 1'b1;
    step();

    lookup(32'h100);
    check("lk100_valid", 32'(bus.predValid), 32'd1);
    check("lk100_taken", 32'(bus.predTaken), 32'd0);
    check("lk100_idx", 32'(bus.predIdx), 32'd0);
    step();
    check("idle_valid_low", 32'(bus.predValid), 32'd0);
    check("idle_idx_hold", 32'(bus.predIdx), 32'd0);

    // 5 mismatches + 3 matches, then 20 more mismatches
    for (int i = 0; i < 5; i++) upd(IDX_W'(10), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) upd(IDX_W'(10), 1'b1, 1'b1);
    check("mispred_5", bus.mispredCount, 32'd5);
    check("mispred4_5", 32'(bus4.mispredCount), 32'd5);
    for (int i = 0; i < 20; i++) upd(IDX_W'(10), 1'b0, 1'b1);
    check("mispred_25", bus.mispredCount, 32'd25);
    check("mispred4_sat", 32'(bus4.mispredCount), 32'd15);

    // Training idx 0: 01 -> 11 -> 00
    upd(IDX_W'(0), 1'b1, 1'b1);
    upd(IDX_W'(0), 1'b1, 1'b1);
    lookup(32'h100);
    check("train_taken", 32'(bus.predTaken), 32'd1);
    upd(IDX_W'(0), 1'b1, 1'b1);
    upd(IDX_W'(0), 1'b1, 1'b1);
    upd(IDX_W'(0), 1'b0, 1'b0);
    lookup(32'h100);
    check("sat_hi_one_dec", 32'(bus.predTaken), 32'd1);
    upd(IDX_W'(0), 1'b0, 1'b0);
    upd(IDX_W'(0), 1'b0, 1'b0);
    upd(IDX_W'(0), 1'b0, 1'b0);
    lookup(32'h100);
    check("train_not_taken", 32'(bus.predTaken), 32'd0);
    upd(IDX_W'(0), 1'b1, 1'b1);
    lookup(32'h100);
    check("sat_lo_one_inc", 32'(bus.predTaken), 32'd0);

    // Same-cycle update + lookup to idx 5 (counter 01 -> 10)
    bus.updValid     = 1'b1;
    bus.updIdx       = IDX_W'(5);
    bus.updTaken     = 1'b1;
    bus.updPredTaken = 1'b1;
    bus.lookupValid  = 1'b1;
    bus.lookupPc     = 32'h014;
    step();
    bus.updValid    = 1'b0;
    bus.lookupValid = 1'b0;
    check("fwd_valid", 32'(bus.predValid), 32'd1);
    check("fwd_taken", 32'(bus.predTaken), 32'd1);
    check("fwd_idx", 32'(bus.predIdx), 32'd5);

    // Flush with concurrent lookup; updates, lookups and flush pulses during sweep are dropped
    upd(IDX_W'(3), 1'b1, 1'b1);
    upd(IDX_W'(3), 1'b1, 1'b1);
    lookup(32'h00C);
    check("idx3_trained", 32'(bus.predTaken), 32'd1);
    bus.flush       = 1'b1;
    bus.lookupValid = 1'b1;
    bus.lookupPc    = 32'h00C;
    step();
    bus.flush = 1'b0;
    check("flush_lk_valid", 32'(bus.predValid), 32'd1);
    check("flush_lk_taken", 32'(bus.predTaken), 32'd1);
    check("flush_busy_set", 32'(bus.flushBusy), 32'd1);
    check("flush_ready_low", 32'(bus.lookupReady), 32'd0);
    bus.updValid     = 1'b1;
    bus.updIdx       = IDX_W'(3);
    bus.updTaken     = 1'b0;
    bus.updPredTaken = 1'b1;
    busy_cnt = 1;
    errs     = 0;
    for (int i = 0; i < 200; i++) begin
      bus.flush = (i == 3);
      step();
      if (!bus.flushBusy) break;
      busy_cnt++;
      if (bus.lookupReady || bus.predValid) errs++;
    end
    bus.flush       = 1'b0;
    bus.updValid    = 1'b0;
    bus.lookupValid = 1'b0;
    check("flush_cycles", busy_cnt, 32'd64);
    check("sweep_ready_valid", errs, 32'd0);
    check("sweep_done_ready", 32'(bus.lookupReady), 32'd1);
    check("sweep_mispred_kept", bus.mispredCount, 32'd25);
    lookup(32'h00C);
    check("post_flush_idx3", 32'(bus.predTaken), 32'd0);
    upd(IDX_W'(0), 1'b1, 1'b1);
    lookup(32'h100);
    check("post_flush_idx0", 32'(bus.predTaken), 32'd1);

    // Reset asserted mid-sweep
    upd(IDX_W'(7), 1'b1, 1'b1);
    upd(IDX_W'(7), 1'b1, 1'b1);
    lookup(32'h01C);
    check("idx7_taken", 32'(bus.predTaken), 32'd1);
    check("idx7_idx", 32'(bus.predIdx), 32'd7);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (9) step();
    check("mid_sweep_busy", 32'(bus.flushBusy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", 32'(bus.flushBusy), 32'd0);
    check("mrst_ready", 32'(bus.lookupReady), 32'd1);
    check("mrst_pred_taken", 32'(bus.predTaken), 32'd0);
    check("mrst_pred_idx", 32'(bus.predIdx), 32'd0);
    check("mrst_mispred", bus.mispredCount, 32'd0);
    check("mrst_mispred4", 32'(bus4.mispredCount), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(bus.flushBusy), 32'd0);
    lookup(32'h01C);
    check("post_rst_idx7", 32'(bus.predTaken), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
